branch_predictor: RTL and testbench

//  IF-stage direction/target predictor; the producer of the branch_predict bit that the EX-stage

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - IF-stage BTB + 2-bit BHT direction/target predictor with statistics
module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_is_cond,
    input  logic        upd_mispredict,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispred
);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                r_valid  [ENTRIES];
    logic                r_uncond [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [31:0]         r_lookups;
    logic [31:0]         r_mispred;

    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic [IDX_BITS-1:0] w_uidx;
    logic [TAG_BITS-1:0] w_utag;
    logic                w_uhit;
    logic                w_unused_pc_lsbs;

    logic       w_set_valid;
    logic       w_wr_tag;
    logic       w_wr_tgt;
    logic       w_wr_uncond;
    logic       w_uncond_val;
    logic       w_wr_ctr;
    logic [1:0] w_ctr_val;

    assign w_unused_pc_lsbs = &{1'b0, upd_pc[1:0]};

    // Lookup is purely combinational; same-cycle updates are not bypassed.
    assign w_idx       = if_pc[IDX_BITS+1:2];
    assign w_tag       = if_pc[31:IDX_BITS+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign pred_taken  = w_hit && (r_uncond[w_idx] || r_ctr[w_idx][1]);
    assign pred_target = pred_taken ? r_target[w_idx] : (if_pc + 32'd4);

    assign w_uidx = upd_pc[IDX_BITS+1:2];
    assign w_utag = upd_pc[31:IDX_BITS+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    always_comb begin
        w_set_valid  = 1'b0;
        w_wr_tag     = 1'b0;
        w_wr_tgt     = 1'b0;
        w_wr_uncond  = 1'b0;
        w_uncond_val = 1'b0;
        w_wr_ctr     = 1'b0;
        w_ctr_val    = r_ctr[w_uidx];
        if (upd_valid) begin
            if (w_uhit && upd_is_cond) begin
                w_wr_ctr    = 1'b1;
                w_wr_uncond = 1'b1;
                w_wr_tgt    = upd_taken;
                if (upd_taken) begin
                    w_ctr_val = (r_ctr[w_uidx] == 2'b11) ? 2'b11 : r_ctr[w_uidx] + 2'd1;
                end else begin
                    w_ctr_val = (r_ctr[w_uidx] == 2'b00) ? 2'b00 : r_ctr[w_uidx] - 2'd1;
                end
            end else if (w_uhit) begin
                w_wr_tgt     = 1'b1;
                w_wr_uncond  = 1'b1;
                w_uncond_val = 1'b1;
            end else if (upd_taken) begin
                // Miss on a taken instruction allocates, evicting any alias at this index.
                w_set_valid  = 1'b1;
                w_wr_tag     = 1'b1;
                w_wr_tgt     = 1'b1;
                w_wr_uncond  = 1'b1;
                w_uncond_val = ~upd_is_cond;
                w_wr_ctr     = 1'b1;
                w_ctr_val    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_valid[k]  <= 1'b0;
                r_uncond[k] <= 1'b0;
                r_ctr[k]    <= 2'b01;
            end
            r_lookups <= 32'd0;
            r_mispred <= 32'd0;
        end else begin
            if (w_set_valid) r_valid[w_uidx]  <= 1'b1;
            if (w_wr_uncond) r_uncond[w_uidx] <= w_uncond_val;
            if (w_wr_ctr)    r_ctr[w_uidx]    <= w_ctr_val;
            if (if_valid)    r_lookups <= r_lookups + 32'd1;
            if (upd_valid && upd_mispredict) r_mispred <= r_mispred + 32'd1;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wr_tag) r_tag[w_uidx]    <= w_utag;
            if (w_wr_tgt) r_target[w_uidx] <= upd_target;
        end
    end

    assign stat_lookups = r_lookups;
    assign stat_mispred = r_mispred;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_cond;
    logic        upd_mispredict;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispred;

    branch_predictor #(.IDX_BITS(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_is_cond    (upd_is_cond),
        .upd_mispredict (upd_mispredict),
        .stat_lookups   (stat_lookups),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] lookups;
        logic [31:0] mispred;
    } exp_t;

    exp_t        sb[$];
    logic        tb_chk = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_lk = 0;
    logic [31:0] exp_mp = 0;
    int          vec = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL vec%0d %s got=%h expected=%h", vec, name, got, want);
        end
    endtask

    // Monitor: pops one expectation per strobed cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (tb_chk) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vec%0d scoreboard_empty got=0 expected=1", vec);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp("pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
                cmp("pred_target", pred_target, e.target);
                cmp("stat_lookups", stat_lookups, e.lookups);
                cmp("stat_mispred", stat_mispred, e.mispred);
            end
        end
    end

    task automatic cyc(input logic rst, input logic vld, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic uc, input logic um,
                       input logic chk, input logic et, input logic [31:0] etgt);
        exp_t e;
        reset = rst; if_valid = vld; if_pc = pc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_is_cond = uc; upd_mispredict = um;
        if (chk) begin
            e.taken = et; e.target = etgt; e.lookups = exp_lk; e.mispred = exp_mp;
            sb.push_back(e);
        end
        tb_chk = chk;
        @(posedge clk); #1;
        if (rst) begin
            exp_lk = 0; exp_mp = 0;
        end else begin
            if (vld) exp_lk = exp_lk + 1;
            if (uv && um) exp_mp = exp_mp + 1;
        end
        tb_chk = 1'b0;
        vec++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        upd_is_cond = 1'b0; upd_mispredict = 1'b0;
        @(posedge clk); #1;
        //  rst vld pc            uv  upc           ut  utgt          uc  um  chk et  etgt
        cyc(1, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);
        cyc(1, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);
        // cold lookup, then allocate BEQ 0x100 -> 0x080
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0500, 1, 32'h0000_0100, 1, 32'h0000_0080, 1, 1, 1, 0, 32'h0000_0504);
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_0080);
        // T,T,N,N with same-cycle lookup showing pre-update state (ctr 10,11,11,10 -> 01)
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0080, 1, 0, 1, 1, 32'h0000_0080);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0080, 1, 0, 1, 1, 32'h0000_0080);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0000_0000, 1, 1, 1, 1, 32'h0000_0080);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0000_0000, 1, 1, 1, 1, 32'h0000_0080);
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0104);
        // taken rewrites target; lookup this cycle is old, next cycle new
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_00C0, 1, 1, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_00C0);
        // drive counter to floor: 10 -> 01 -> 00 -> 00 -> 01
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0000_0000, 1, 1, 1, 1, 32'h0000_00C0);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0000_0000, 1, 0, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 0, 32'h0000_0000, 1, 0, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_00C0, 1, 0, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0104);
        // JAL 0x200 -> 0x400 evicts 0x100 (same index 0), then re-hit as unconditional
        cyc(0, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 32'h0000_0400, 0, 1, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'h0000_0200, 1, 32'h0000_0200, 1, 32'h0000_0400, 0, 0, 1, 1, 32'h0000_0400);
        cyc(0, 1, 32'h0000_0200, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_0400);
        cyc(0, 1, 32'h0000_0300, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0304);
        cyc(0, 1, 32'h0000_0100, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0104);
        cyc(0, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0000);
        // not-taken miss never allocates
        cyc(0, 0, 32'h0000_0000, 1, 32'h0000_0340, 0, 32'h0000_0000, 1, 0, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_0340, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0344);
        // train 0x344, then reset with a concurrent update that must be discarded
        cyc(0, 0, 32'h0000_0000, 1, 32'h0000_0344, 1, 32'h0000_0010, 1, 1, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_0344, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_0010);
        cyc(1, 1, 32'h0000_0344, 1, 32'h0000_0348, 1, 32'h0000_0020, 1, 1, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_0348, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_034C);
        cyc(0, 1, 32'h0000_0344, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0348);
        cyc(0, 1, 32'h0000_0200, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 1, 0, 32'h0000_0204);
        cyc(0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 0, 32'h0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
